stage_envelope_generator: RTL and testbench
===========================================

Name: stage_envelope_generator

Overview:
- Pipeline stage directly downstream of the waveform generator stage.
- Keeps per-slot ADSR envelope state, indexed by VoiceOperatorID_t, and updates it once each time a slot passes through.
- Scales the incoming signed waveform sample by the updated envelope level.
- Forwards VoiceOperator, AlgorithmWord and NoteOn with matching latency to the operator-mixing stage.

Parameters:
- NUM_SLOTS, default 2**$bits(VoiceOperatorID_t): number of envelope state entries, one per voice-operator ID.
- LEVEL_WIDTH, default 16: envelope level and config data width. The design is only required to support 16.

Ports:
- i_Clock  in  1  system clock.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_VoiceOperator  in  VoiceOperatorID_t  slot ID of the incoming sample.
- o_VoiceOperator  out  VoiceOperatorID_t  delayed i_VoiceOperator.
- i_AlgorithmWord  in  AlgorithmWord_t  passed through.
- o_AlgorithmWord  out  AlgorithmWord_t  delayed i_AlgorithmWord.
- i_NoteOn  in  1  key state for this slot.
- o_NoteOn  out  1  delayed i_NoteOn.
- i_Waveform  in  16 signed  sample from the waveform generator.
- o_Waveform  out  16 signed  enveloped sample.
- o_Level  out  16 unsigned  envelope level applied to o_Waveform (debug/verification).
- i_ConfigWriteEnable  in  1  config write strobe.
- i_ConfigSlot  in  VoiceOperatorID_t  target slot of the config write.
- i_ConfigParam  in  2  0=attack rate, 1=decay rate, 2=sustain level, 3=release rate.
- i_ConfigData  in  16 unsigned  config value.

Behaviour:
- Reset: async on i_Reset_n low. For every slot: state=IDLE, level=0, prevNoteOn=0, all four config registers=0. All o_* outputs=0 and all pipeline registers=0. Reset mid-stream discards in-flight samples.
- Per-slot storage: state (IDLE/ATTACK/DECAY/SUSTAIN/RELEASE), level[15:0], prevNoteOn, AR, DR, SL, RR.
- Clock 1 (read-modify-write):
  - State, level and config for i_VoiceOperator are read combinationally; next values are written back on the same edge.
  - Consequence: the same ID on consecutive cycles sees the updated values, so there is no hazard.
- Next-state rules, evaluated in priority order:
  1. i_NoteOn=1 && prevNoteOn=0 → ATTACK. Level is unchanged this visit (attack continues from the current level, including mid-RELEASE).
  2. i_NoteOn=0 && prevNoteOn=1 → RELEASE. Level is unchanged this visit.
  3. Otherwise, by state:
     - ATTACK: level = min(level+AR, 0xFFFF), 17-bit sum. If the result is 0xFFFF → DECAY.
     - DECAY: if level <= SL or level-DR <= SL (including underflow), level=SL and → SUSTAIN; else level -= DR.
     - SUSTAIN: level held (later SL changes do not move it).
     - RELEASE: if level <= RR, level=0 and → IDLE; else level -= RR.
     - IDLE: level=0.
- prevNoteOn <= i_NoteOn on every visit.
- Rate of 0: ATTACK/DECAY/RELEASE stall indefinitely (legal).
- Clock 1 also registers i_Waveform, the new level and the sideband signals.
- Clock 2: product = signed(waveform) × signed({1'b0, level}), 33-bit, registered.
- Clock 3:
  - o_Waveform = product[31:16] (arithmetic shift right 16, floor rounding).
  - o_Level = level.
  - Sideband outputs updated.
- Latency: exactly 3 cycles, input to output, for all outputs. One sample accepted every cycle, no stalls.
- Config writes:
  - Take effect on the clock edge.
  - A write to the slot being evaluated in the same cycle is not seen by that evaluation; it applies from the next visit.
  - Config writes never alter state, level or prevNoteOn.
- Slots not presented on i_VoiceOperator never change.

Test Plan:
- Reset → all outputs 0. Slot 5 with i_Waveform=0x4000, NoteOn=0 → o_Waveform=0, o_Level=0 three cycles later.
- Attack ramp: slot 3 AR=0x4000, DR=0x1000, SL=0x8000; NoteOn held 1; waveform 0x4000 each visit.
  - Visits give o_Level 0, 0x4000, 0x8000, 0xC000, 0xFFFF (now DECAY), then 0xEFFF, ...
  - Visits continue down to 0x8000, then hold (SUSTAIN).
  - At level 0xFFFF, o_Waveform=0x3FFF; with waveform 0xC000 it is 0xC000.
- Release: from SUSTAIN 0x8000 with RR=0x3000, NoteOn→0.
  - Visits give 0x8000, 0x5000, 0x2000, 0 (IDLE), then 0 thereafter.
- Retrigger: NoteOn 1 during RELEASE at level 0x5000 → next visit level 0x5000 (ATTACK), following visit 0x5000+AR.
- Back-to-back/interleave:
  - Slot 7 presented on two consecutive cycles with AR=0x100 → levels 0x000, 0x100.
  - Interleaved slots 1/2 evolve independently.
  - Same-cycle config write to slot 7 is not used until the next visit.
- Async reset asserted mid-ATTACK with samples in flight → outputs 0 immediately. After release, the slot restarts from IDLE/level 0 and the config reads 0.

Source files
------------

// File: rtl/stage_envelope_generator_if.sv
// Shared types and the sample/config bus of the envelope stage.
// The master side drives the incoming sample, the sideband and the
// config writes, and receives the enveloped sample.

package stage_envelope_generator_pkg;
  typedef logic [3:0] VoiceOperatorID_t;
  typedef logic [7:0] AlgorithmWord_t;
endpackage

interface stage_envelope_generator_if;
  import stage_envelope_generator_pkg::*;

  VoiceOperatorID_t   i_VoiceOperator;
  AlgorithmWord_t     i_AlgorithmWord;
  logic               i_NoteOn;
  logic signed [15:0] i_Waveform;
  logic               i_ConfigWriteEnable;
  VoiceOperatorID_t   i_ConfigSlot;
  logic [1:0]         i_ConfigParam;
  logic [15:0]        i_ConfigData;

  VoiceOperatorID_t   o_VoiceOperator;
  AlgorithmWord_t     o_AlgorithmWord;
  logic               o_NoteOn;
  logic signed [15:0] o_Waveform;
  logic [15:0]        o_Level;

  modport master (
    output i_VoiceOperator, i_AlgorithmWord, i_NoteOn, i_Waveform,
           i_ConfigWriteEnable, i_ConfigSlot, i_ConfigParam, i_ConfigData,
    input  o_VoiceOperator, o_AlgorithmWord, o_NoteOn, o_Waveform, o_Level
  );

  modport slave (
    input  i_VoiceOperator, i_AlgorithmWord, i_NoteOn, i_Waveform,
           i_ConfigWriteEnable, i_ConfigSlot, i_ConfigParam, i_ConfigData,
    output o_VoiceOperator, o_AlgorithmWord, o_NoteOn, o_Waveform, o_Level
  );
endinterface

// File: rtl/stage_envelope_generator.sv
// Per-slot ADSR envelope stage. Each incoming sample updates the envelope
// of its slot (read-modify-write in one cycle), the sample is scaled by the
// new level, and everything leaves exactly three cycles after it entered.

module stage_envelope_generator
  import stage_envelope_generator_pkg::*;
#(
  parameter int NUM_SLOTS   = 2**$bits(VoiceOperatorID_t),
  parameter int LEVEL_WIDTH = 16
) (
  input logic                      i_Clock,
  input logic                      i_Reset_n,
  stage_envelope_generator_if.slave bus
);

  localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX = '1;
  localparam int PROD_WIDTH = 16 + LEVEL_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_DECAY,
    ST_SUSTAIN,
    ST_RELEASE
  } env_state_t;

  env_state_t             state_mem     [NUM_SLOTS];
  logic [LEVEL_WIDTH-1:0] level_mem     [NUM_SLOTS];
  logic                   prev_note_mem [NUM_SLOTS];
  logic [LEVEL_WIDTH-1:0] ar_mem        [NUM_SLOTS];
  logic [LEVEL_WIDTH-1:0] dr_mem        [NUM_SLOTS];
  logic [LEVEL_WIDTH-1:0] sl_mem        [NUM_SLOTS];
  logic [LEVEL_WIDTH-1:0] rr_mem        [NUM_SLOTS];

  env_state_t             cur_state;
  env_state_t             next_state;
  logic [LEVEL_WIDTH-1:0] cur_level;
  logic [LEVEL_WIDTH-1:0] next_level;
  logic [LEVEL_WIDTH-1:0] cur_ar;
  logic [LEVEL_WIDTH-1:0] cur_dr;
  logic [LEVEL_WIDTH-1:0] cur_sl;
  logic [LEVEL_WIDTH-1:0] cur_rr;
  logic                   cur_prev;
  logic [LEVEL_WIDTH:0]   attack_sum;
  logic [LEVEL_WIDTH:0]   decay_diff;

  VoiceOperatorID_t       vo_s1;
  AlgorithmWord_t         alg_s1;
  logic                   note_s1;
  logic signed [15:0]     wave_s1;
  logic [LEVEL_WIDTH-1:0] level_s1;

  VoiceOperatorID_t       vo_s2;
  AlgorithmWord_t         alg_s2;
  logic                   note_s2;
  logic [LEVEL_WIDTH-1:0] level_s2;
  logic signed [PROD_WIDTH-1:0] product_s2;

  logic signed [PROD_WIDTH-1:0] wave_ext;
  logic signed [PROD_WIDTH-1:0] level_ext;
  logic signed [PROD_WIDTH-1:0] product_full;
  logic                         unused_product_bits;

  // Next envelope state/level for the slot currently presented; edge events on NoteOn win over the per-state ramp.
  always_comb begin
    cur_state  = state_mem[bus.i_VoiceOperator];
    cur_level  = level_mem[bus.i_VoiceOperator];
    cur_prev   = prev_note_mem[bus.i_VoiceOperator];
    cur_ar     = ar_mem[bus.i_VoiceOperator];
    cur_dr     = dr_mem[bus.i_VoiceOperator];
    cur_sl     = sl_mem[bus.i_VoiceOperator];
    cur_rr     = rr_mem[bus.i_VoiceOperator];
    attack_sum = {1'b0, cur_level} + {1'b0, cur_ar};
    decay_diff = {1'b0, cur_level} - {1'b0, cur_dr};
    next_state = cur_state;
    next_level = cur_level;
    if (bus.i_NoteOn && !cur_prev) begin
      next_state = ST_ATTACK;
    end else if (!bus.i_NoteOn && cur_prev) begin
      next_state = ST_RELEASE;
    end else begin
      case (cur_state)
        ST_ATTACK: begin
          if (attack_sum[LEVEL_WIDTH] || (attack_sum[LEVEL_WIDTH-1:0] == LEVEL_MAX)) begin
            next_level = LEVEL_MAX;
            next_state = ST_DECAY;
          end else begin
            next_level = attack_sum[LEVEL_WIDTH-1:0];
          end
        end
        ST_DECAY: begin
          if ((cur_level <= cur_sl) || decay_diff[LEVEL_WIDTH] ||
              (decay_diff[LEVEL_WIDTH-1:0] <= cur_sl)) begin
            next_level = cur_sl;
            next_state = ST_SUSTAIN;
          end else begin
            next_level = decay_diff[LEVEL_WIDTH-1:0];
          end
        end
        ST_SUSTAIN: begin
          next_level = cur_level;
        end
        ST_RELEASE: begin
          if (cur_level <= cur_rr) begin
            next_level = '0;
            next_state = ST_IDLE;
          end else begin
            next_level = cur_level - cur_rr;
          end
        end
        default: begin
          next_level = '0;
        end
      endcase
    end
  end

  // Write back the evaluated slot's envelope; all other slots are untouched.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        state_mem[s]     <= ST_IDLE;
        level_mem[s]     <= '0;
        prev_note_mem[s] <= 1'b0;
      end
    end else begin
      state_mem[bus.i_VoiceOperator]     <= next_state;
      level_mem[bus.i_VoiceOperator]     <= next_level;
      prev_note_mem[bus.i_VoiceOperator] <= bus.i_NoteOn;
    end
  end

  // Config registers; a write lands on the edge, so the same-cycle evaluation still sees the old value.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        ar_mem[s] <= '0;
        dr_mem[s] <= '0;
        sl_mem[s] <= '0;
        rr_mem[s] <= '0;
      end
    end else if (bus.i_ConfigWriteEnable) begin
      case (bus.i_ConfigParam)
        2'd0:    ar_mem[bus.i_ConfigSlot] <= bus.i_ConfigData;
        2'd1:    dr_mem[bus.i_ConfigSlot] <= bus.i_ConfigData;
        2'd2:    sl_mem[bus.i_ConfigSlot] <= bus.i_ConfigData;
        default: rr_mem[bus.i_ConfigSlot] <= bus.i_ConfigData;
      endcase
    end
  end

  // Stage 1: capture the sample, the freshly computed level and the sideband.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      vo_s1    <= '0;
      alg_s1   <= '0;
      note_s1  <= 1'b0;
      wave_s1  <= '0;
      level_s1 <= '0;
    end else begin
      vo_s1    <= bus.i_VoiceOperator;
      alg_s1   <= bus.i_AlgorithmWord;
      note_s1  <= bus.i_NoteOn;
      wave_s1  <= bus.i_Waveform;
      level_s1 <= next_level;
    end
  end

  // Level is treated as a non-negative signed factor so the product keeps the sample's sign.
  assign wave_ext     = {{(LEVEL_WIDTH + 1){wave_s1[15]}}, wave_s1};
  assign level_ext    = {{17{1'b0}}, level_s1};
  assign product_full = wave_ext * level_ext;

  // Stage 2: register the full-precision product alongside the delayed sideband.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      vo_s2      <= '0;
      alg_s2     <= '0;
      note_s2    <= 1'b0;
      level_s2   <= '0;
      product_s2 <= '0;
    end else begin
      vo_s2      <= vo_s1;
      alg_s2     <= alg_s1;
      note_s2    <= note_s1;
      level_s2   <= level_s1;
      product_s2 <= product_full;
    end
  end

  // Dropping the low bits is an arithmetic shift with floor rounding; the top bit is only sign extension.
  assign unused_product_bits = ^{product_s2[PROD_WIDTH-1], product_s2[LEVEL_WIDTH-1:0]};

  // Stage 3: registered outputs toward the operator mixer.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      bus.o_VoiceOperator <= '0;
      bus.o_AlgorithmWord <= '0;
      bus.o_NoteOn        <= 1'b0;
      bus.o_Waveform      <= '0;
      bus.o_Level         <= '0;
    end else begin
      bus.o_VoiceOperator <= vo_s2;
      bus.o_AlgorithmWord <= alg_s2;
      bus.o_NoteOn        <= note_s2;
      bus.o_Waveform      <= product_s2[LEVEL_WIDTH+15:LEVEL_WIDTH];
      bus.o_Level         <= level_s2;
    end
  end

endmodule

// File: tb/tb_stage_envelope_generator.sv
// Directed bench for the envelope stage: samples are streamed one per cycle
// and each output is captured three edges after its input was applied.

module tb_stage_envelope_generator;
  import stage_envelope_generator_pkg::*;

  localparam int MAXS = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stage_envelope_generator_if bus();

  stage_envelope_generator dut (
    .i_Clock  (clk),
    .i_Reset_n(rst_n),
    .bus      (bus)
  );

  logic [3:0]  s_slot      [MAXS];
  logic        s_note      [MAXS];
  logic [15:0] s_wave      [MAXS];
  logic        s_cfg_en    [MAXS];
  logic [3:0]  s_cfg_slot  [MAXS];
  logic [1:0]  s_cfg_param [MAXS];
  logic [15:0] s_cfg_data  [MAXS];
  int          s_len;

  logic [15:0] r_level [MAXS];
  logic [15:0] r_wave  [MAXS];
  logic [3:0]  r_vo    [MAXS];
  logic [7:0]  r_alg   [MAXS];
  logic        r_note  [MAXS];

  // Slot 15 is never configured, so visiting it with NoteOn low leaves it idle.
  task drive_filler();
    bus.i_VoiceOperator     = 4'hF;
    bus.i_AlgorithmWord     = 8'h00;
    bus.i_NoteOn            = 1'b0;
    bus.i_Waveform          = 16'sh0000;
    bus.i_ConfigWriteEnable = 1'b0;
    bus.i_ConfigSlot        = 4'h0;
    bus.i_ConfigParam       = 2'd0;
    bus.i_ConfigData        = 16'h0000;
  endtask

  task add_elem(input logic [3:0] slot, input logic note, input logic [15:0] wave);
    s_slot[s_len]   = slot;
    s_note[s_len]   = note;
    s_wave[s_len]   = wave;
    s_cfg_en[s_len] = 1'b0;
    s_cfg_slot[s_len]  = 4'h0;
    s_cfg_param[s_len] = 2'd0;
    s_cfg_data[s_len]  = 16'h0000;
    s_len++;
  endtask

  // Drives the queued elements back to back; element j appears after edge j+3.
  task run_stream();
    for (int i = 0; i < s_len + 2; i++) begin
      if (i < s_len) begin
        bus.i_VoiceOperator     = s_slot[i];
        bus.i_AlgorithmWord     = {4'hA, s_slot[i]};
        bus.i_NoteOn            = s_note[i];
        bus.i_Waveform          = s_wave[i];
        bus.i_ConfigWriteEnable = s_cfg_en[i];
        bus.i_ConfigSlot        = s_cfg_slot[i];
        bus.i_ConfigParam       = s_cfg_param[i];
        bus.i_ConfigData        = s_cfg_data[i];
      end else begin
        drive_filler();
      end
      @(posedge clk);
      #1;
      if (i >= 2) begin
        r_level[i-2] = bus.o_Level;
        r_wave[i-2]  = bus.o_Waveform;
        r_vo[i-2]    = bus.o_VoiceOperator;
        r_alg[i-2]   = bus.o_AlgorithmWord;
        r_note[i-2]  = bus.o_NoteOn;
      end
    end
    drive_filler();
  endtask

  task cfg_write(input logic [3:0] slot, input logic [1:0] param, input logic [15:0] data);
    bus.i_ConfigWriteEnable = 1'b1;
    bus.i_ConfigSlot        = slot;
    bus.i_ConfigParam       = param;
    bus.i_ConfigData        = data;
    @(posedge clk);
    #1;
    drive_filler();
  endtask

  task test_reset();
    rst_n = 1'b0;
    drive_filler();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.o_Level !== 16'h0) begin errors++; $display("FAIL reset_level got %h want 0000", bus.o_Level); end
    checks++; if (bus.o_Waveform !== 16'sh0) begin errors++; $display("FAIL reset_wave got %h want 0000", bus.o_Waveform); end
    checks++; if (bus.o_VoiceOperator !== 4'h0) begin errors++; $display("FAIL reset_vo got %h want 0", bus.o_VoiceOperator); end
    checks++; if (bus.o_AlgorithmWord !== 8'h0) begin errors++; $display("FAIL reset_alg got %h want 00", bus.o_AlgorithmWord); end
    checks++; if (bus.o_NoteOn !== 1'b0) begin errors++; $display("FAIL reset_note got %b want 0", bus.o_NoteOn); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    s_len = 0;
    add_elem(4'd5, 1'b0, 16'h4000);
    run_stream();
    checks++; if (r_level[0] !== 16'h0) begin errors++; $display("FAIL idle_level got %h want 0000", r_level[0]); end
    checks++; if (r_wave[0] !== 16'h0) begin errors++; $display("FAIL idle_wave got %h want 0000", r_wave[0]); end
    checks++; if (r_vo[0] !== 4'h5) begin errors++; $display("FAIL idle_vo got %h want 5", r_vo[0]); end
    checks++; if (r_alg[0] !== 8'hA5) begin errors++; $display("FAIL idle_alg got %h want a5", r_alg[0]); end
    checks++; if (r_note[0] !== 1'b0) begin errors++; $display("FAIL idle_note got %b want 0", r_note[0]); end
  endtask

  task test_attack_decay();
    logic [15:0] exp_lv [14];
    exp_lv = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'hFFFF, 16'hEFFF, 16'hDFFF,
               16'hCFFF, 16'hBFFF, 16'hAFFF, 16'h9FFF, 16'h8FFF, 16'h8000, 16'h8000};
    cfg_write(4'd3, 2'd0, 16'h4000);
    cfg_write(4'd3, 2'd1, 16'h1000);
    cfg_write(4'd3, 2'd2, 16'h8000);
    s_len = 0;
    for (int i = 0; i < 14; i++) add_elem(4'd3, 1'b1, 16'h4000);
    run_stream();
    for (int i = 0; i < 14; i++) begin
      checks++; if (r_level[i] !== exp_lv[i]) begin errors++; $display("FAIL adsr_level[%0d] got %h want %h", i, r_level[i], exp_lv[i]); end
      checks++; if (r_wave[i] !== (exp_lv[i] >> 2)) begin errors++; $display("FAIL adsr_wave[%0d] got %h want %h", i, r_wave[i], exp_lv[i] >> 2); end
    end
    checks++; if (r_note[4] !== 1'b1 || r_vo[4] !== 4'd3) begin errors++; $display("FAIL adsr_sideband got vo=%h note=%b want vo=3 note=1", r_vo[4], r_note[4]); end
  endtask

  task test_full_scale();
    logic [15:0] exp_wv [4];
    logic [15:0] exp_lv [4];
    exp_lv = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    exp_wv = '{16'h0000, 16'hC000, 16'h8000, 16'h7FFE};
    cfg_write(4'd4, 2'd0, 16'hFFFF);
    s_len = 0;
    add_elem(4'd4, 1'b1, 16'h4000);
    add_elem(4'd4, 1'b1, 16'hC000);
    add_elem(4'd4, 1'b1, 16'h8000);
    add_elem(4'd4, 1'b1, 16'h7FFF);
    run_stream();
    for (int i = 0; i < 4; i++) begin
      checks++; if (r_level[i] !== exp_lv[i]) begin errors++; $display("FAIL full_level[%0d] got %h want %h", i, r_level[i], exp_lv[i]); end
      checks++; if (r_wave[i] !== exp_wv[i]) begin errors++; $display("FAIL full_wave[%0d] got %h want %h", i, r_wave[i], exp_wv[i]); end
    end
  endtask

  task test_release();
    logic [15:0] exp_lv [5];
    exp_lv = '{16'h8000, 16'h5000, 16'h2000, 16'h0000, 16'h0000};
    cfg_write(4'd3, 2'd3, 16'h3000);
    s_len = 0;
    for (int i = 0; i < 5; i++) add_elem(4'd3, 1'b0, 16'h4000);
    run_stream();
    for (int i = 0; i < 5; i++) begin
      checks++; if (r_level[i] !== exp_lv[i]) begin errors++; $display("FAIL release_level[%0d] got %h want %h", i, r_level[i], exp_lv[i]); end
      checks++; if (r_wave[i] !== (exp_lv[i] >> 2)) begin errors++; $display("FAIL release_wave[%0d] got %h want %h", i, r_wave[i], exp_lv[i] >> 2); end
    end
  endtask

  task test_retrigger();
    logic [15:0] exp_lv [7];
    logic        notes  [7];
    exp_lv = '{16'h0000, 16'h5000, 16'h5000, 16'h5000, 16'hA000, 16'hF000, 16'hFFFF};
    notes  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    cfg_write(4'd6, 2'd0, 16'h5000);
    cfg_write(4'd6, 2'd3, 16'h1000);
    s_len = 0;
    for (int i = 0; i < 7; i++) add_elem(4'd6, notes[i], 16'h4000);
    run_stream();
    for (int i = 0; i < 7; i++) begin
      checks++; if (r_level[i] !== exp_lv[i]) begin errors++; $display("FAIL retrig_level[%0d] got %h want %h", i, r_level[i], exp_lv[i]); end
      checks++; if (r_note[i] !== notes[i]) begin errors++; $display("FAIL retrig_note[%0d] got %b want %b", i, r_note[i], notes[i]); end
    end
  endtask

  task test_back_to_back();
    logic [15:0] exp_lv [4];
    exp_lv = '{16'h0000, 16'h0100, 16'h0200, 16'h1200};
    cfg_write(4'd7, 2'd0, 16'h0100);
    s_len = 0;
    for (int i = 0; i < 4; i++) add_elem(4'd7, 1'b1, 16'h4000);
    s_cfg_en[2]    = 1'b1;
    s_cfg_slot[2]  = 4'd7;
    s_cfg_param[2] = 2'd0;
    s_cfg_data[2]  = 16'h1000;
    run_stream();
    for (int i = 0; i < 4; i++) begin
      checks++; if (r_level[i] !== exp_lv[i]) begin errors++; $display("FAIL b2b_level[%0d] got %h want %h", i, r_level[i], exp_lv[i]); end
      checks++; if (r_vo[i] !== 4'd7) begin errors++; $display("FAIL b2b_vo[%0d] got %h want 7", i, r_vo[i]); end
    end
  endtask

  task test_interleave();
    logic [3:0]  slots  [8];
    logic        notes  [8];
    logic [15:0] exp_lv [8];
    slots  = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2};
    notes  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_lv = '{16'h0000, 16'h0000, 16'h1000, 16'h2000, 16'h2000, 16'h4000, 16'h2000, 16'h6000};
    cfg_write(4'd1, 2'd0, 16'h1000);
    cfg_write(4'd2, 2'd0, 16'h2000);
    s_len = 0;
    for (int i = 0; i < 8; i++) add_elem(slots[i], notes[i], 16'h4000);
    run_stream();
    for (int i = 0; i < 8; i++) begin
      checks++; if (r_level[i] !== exp_lv[i]) begin errors++; $display("FAIL inter_level[%0d] got %h want %h", i, r_level[i], exp_lv[i]); end
      checks++; if (r_vo[i] !== slots[i] || r_alg[i] !== {4'hA, slots[i]}) begin errors++; $display("FAIL inter_side[%0d] got vo=%h alg=%h want vo=%h alg=%h", i, r_vo[i], r_alg[i], slots[i], {4'hA, slots[i]}); end
    end
  endtask

  task test_async_reset();
    cfg_write(4'd9, 2'd0, 16'h1000);
    for (int i = 0; i < 4; i++) begin
      bus.i_VoiceOperator = 4'd9;
      bus.i_AlgorithmWord = 8'hA9;
      bus.i_NoteOn        = 1'b1;
      bus.i_Waveform      = 16'sh4000;
      @(posedge clk);
      #1;
    end
    checks++; if (bus.o_Level !== 16'h1000) begin errors++; $display("FAIL pre_reset_level got %h want 1000", bus.o_Level); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_Level !== 16'h0) begin errors++; $display("FAIL async_level got %h want 0000", bus.o_Level); end
    checks++; if (bus.o_Waveform !== 16'sh0) begin errors++; $display("FAIL async_wave got %h want 0000", bus.o_Waveform); end
    checks++; if (bus.o_VoiceOperator !== 4'h0 || bus.o_NoteOn !== 1'b0 || bus.o_AlgorithmWord !== 8'h0) begin errors++; $display("FAIL async_side got vo=%h note=%b alg=%h want zeros", bus.o_VoiceOperator, bus.o_NoteOn, bus.o_AlgorithmWord); end
    drive_filler();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.o_Level !== 16'h0 || bus.o_VoiceOperator !== 4'h0) begin errors++; $display("FAIL flushed_pipe got level=%h vo=%h want 0000/0", bus.o_Level, bus.o_VoiceOperator); end
    s_len = 0;
    add_elem(4'd9, 1'b1, 16'h4000);
    add_elem(4'd9, 1'b1, 16'h4000);
    run_stream();
    for (int i = 0; i < 2; i++) begin
      checks++; if (r_level[i] !== 16'h0) begin errors++; $display("FAIL post_reset_level[%0d] got %h want 0000", i, r_level[i]); end
      checks++; if (r_vo[i] !== 4'd9 || r_note[i] !== 1'b1) begin errors++; $display("FAIL post_reset_side[%0d] got vo=%h note=%b want 9/1", i, r_vo[i], r_note[i]); end
    end
  endtask

  // Runs every scenario in order and prints the tally.
  initial begin
    rst_n = 1'b0;
    drive_filler();
    test_reset();
    test_attack_decay();
    test_full_scale();
    test_release();
    test_retrigger();
    test_back_to_back();
    test_interleave();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guards against a run that never completes.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
